// File: rtl/buffered_oport_pkg.sv
// Shared types and constants for buffered_oport: Z80 bus structs, status/control
// bit positions, channel-width helper and the status-byte formatter.
package buffered_oport_pkg;

  localparam int STAT_FULL    = 7;
  localparam int STAT_EMPTY   = 6;
  localparam int CTRL_FLUSH   = 0;
  localparam int STAT_CNT_MAX = 63;

  typedef struct packed {
    logic [7:0] dmaster;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;

  function automatic int chan_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

  localparam int NUM_CH_DEF = 2;
  localparam int CH_W_DEF   = chan_width(NUM_CH_DEF);

  typedef struct packed {
    logic [CH_W_DEF-1:0] chan;
    logic [7:0]          data;
  } entry_t;

  // Occupancy is clamped so it never aliases into the flag bits.
  function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                             input logic [31:0] count);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    if (count > 32'(STAT_CNT_MAX)) begin
      s[5:0] = 6'd63;
    end else begin
      s[5:0] = count[5:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/buffered_oport_chk.sv
// Invariant checker for buffered_oport: a commit must always find a free slot.
module buffered_oport_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  commit_has_slot: assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush; full and empty are derived
// from the occupancy count so pointers may wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Flag decode and qualified push/pop; flush overrides both.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    do_push_s = push & ~flush & (~full | pop);
    do_pop_s  = pop & ~flush & ~empty;
    count     = count_r;
    dout      = mem[rd_ptr_r];
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/buffered_oport.sv
// Buffered multi-channel Z80 output port: strobe decode, wait-state and status
// logic around a sync_fifo. Define BUFFERED_OPORT_CONSOLE_EN to echo drained bytes.
module buffered_oport
  import buffered_oport_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  localparam int CH_W  = chan_width(NUM_CH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_ena,
  input  logic             rd_ena,
  input  logic [CH_W-1:0]  chan_sel,
  input  Z80MasterBus      ibus,
  output Z80SlaveBus       obus,
  output logic [7:0]       tx_data,
  output logic [CH_W-1:0]  tx_chan,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] fifo_count
);

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic [7:0]      data;
  } oport_entry_t;

  logic            wr_delay_r;
  logic            wr_prev_r;
  logic [CH_W-1:0] chan_r;
  logic [7:0]      data_r;
  logic            commit_s;
  logic            push_s;
  logic            flush_s;
  logic            pop_s;
  logic            ready_s;
  logic            full_s;
  logic            empty_s;
  logic            data_sel_s;
  logic            ctrl_sel_s;
  logic [CNT_W-1:0] count_s;
  oport_entry_t    din_s;
  oport_entry_t    head_s;

  // wr_prev_r resets high so a strobe straddling reset release cannot arm a commit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_delay_r <= 1'b0;
      wr_prev_r  <= 1'b1;
      chan_r     <= {CH_W{1'b0}};
      data_r     <= 8'h00;
    end else begin
      wr_prev_r <= wr_ena;
      if (wr_ena) begin
        wr_delay_r <= wr_delay_r | ~wr_prev_r;
        chan_r     <= chan_sel;
        data_r     <= ibus.dmaster;
      end else begin
        wr_delay_r <= 1'b0;
      end
    end
  end

  // Commit decode: data channels push, the control channel may flush.
  always_comb begin
    commit_s   = wr_delay_r & ~wr_ena;
    data_sel_s = (32'(chan_sel) < 32'(NUM_CH));
    ctrl_sel_s = (chan_sel == CH_W'(NUM_CH));
    push_s     = 1'b0;
    flush_s    = 1'b0;
    din_s.chan = chan_r;
    din_s.data = data_r;
    if (commit_s) begin
      if (32'(chan_r) < 32'(NUM_CH)) begin
        push_s = 1'b1;
      end else if (chan_r == CH_W'(NUM_CH)) begin
        flush_s = data_r[CTRL_FLUSH];
      end else begin
        push_s  = 1'b0;
        flush_s = 1'b0;
      end
    end else begin
      push_s  = 1'b0;
      flush_s = 1'b0;
    end
    pop_s = ~empty_s & ready_s;
  end

`ifdef BUFFERED_OPORT_CONSOLE_EN
  assign ready_s = 1'b1;

  // Console echo of every drained byte.
  always_ff @(posedge clk) begin
    if (!rst_n && pop_s) $write("%c", tx_data);
  end
`else
  assign ready_s = tx_ready;
`endif

  sync_fifo #(
    .WIDTH (CH_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (din_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  buffered_oport_chk u_chk (
    .clk  (clk),
    .rst  (rst_n),
    .push (push_s),
    .full (full_s)
  );

  // CPU-facing wait/status and stream outputs, all from registered FIFO state.
  always_comb begin
    obus.mwait  = 1'b1;
    obus.dslave = 8'h00;
    if (wr_ena && data_sel_s && full_s) begin
      obus.mwait = 1'b0;
    end else begin
      obus.mwait = 1'b1;
    end
    if (rd_ena && ctrl_sel_s) begin
      obus.dslave = status_byte(full_s, empty_s, 32'(count_s));
    end else begin
      obus.dslave = 8'h00;
    end
    tx_valid   = ~empty_s;
    fifo_count = count_s;
    if (empty_s) begin
      tx_data = 8'h00;
      tx_chan = {CH_W{1'b0}};
    end else begin
      tx_data = head_s.data;
      tx_chan = head_s.chan;
    end
  end

endmodule

// File: tb/tb_buffered_oport.sv
// Self-checking bench for buffered_oport: queue-based reference model, a vector
// table, hand-written corner sequences and a randomized write/drain run.
module tb_buffered_oport;
  import buffered_oport_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 5;

  typedef struct {
    int chan;
    int data;
    int len;
    int exp_count;
    int exp_status;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             wr_ena;
  logic             rd_ena;
  logic [CH_W-1:0]  chan_sel;
  Z80MasterBus      ibus;
  Z80SlaveBus       obus;
  logic [7:0]       tx_data;
  logic [CH_W-1:0]  tx_chan;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] fifo_count;

  int total = 0;
  int bad = 0;
  int q[$];
  bit m_act;
  bit m_block;
  int m_chan;
  int m_data;
  int coincide = 0;

  buffered_oport dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ena     (wr_ena),
    .rd_ena     (rd_ena),
    .chan_sel   (chan_sel),
    .ibus       (ibus),
    .obus       (obus),
    .tx_data    (tx_data),
    .tx_chan    (tx_chan),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_status();
    int c;
    c = q.size();
    return ((c == DEPTH) ? 128 : 0) + ((c == 0) ? 64 : 0) + ((c > 63) ? 63 : c);
  endfunction

  task automatic check_all();
    chk("tx_valid", 32'(tx_valid), (q.size() > 0) ? 1 : 0);
    chk("fifo_count", 32'(fifo_count), q.size());
    if (q.size() > 0) begin
      chk("tx_data", 32'(tx_data), q[0] % 256);
      chk("tx_chan", 32'(tx_chan), q[0] / 256);
    end
    chk("mwait", 32'(obus.mwait),
        (wr_ena && int'(chan_sel) < NUM_CH && q.size() == DEPTH) ? 0 : 1);
    chk("dslave", 32'(obus.dslave),
        (rd_ena && int'(chan_sel) == NUM_CH) ? exp_status() : 0);
  endtask

  // One clock: predict the edge from the port rules, then compare just after it.
  task automatic step();
    bit pop_now;
    pop_now = tx_ready && (q.size() > 0);
    @(posedge clk);
    if (rst_n) begin
      q.delete();
      m_act = 1'b0;
      m_block = 1'b1;
    end else begin
      if (pop_now) void'(q.pop_front());
      if (wr_ena) begin
        if (!m_block) begin
          m_act = 1'b1;
          m_chan = int'(chan_sel);
          m_data = int'(ibus.dmaster);
        end
      end else begin
        m_block = 1'b0;
        if (m_act) begin
          m_act = 1'b0;
          if (m_chan < NUM_CH) begin
            q.push_back(m_chan * 256 + m_data);
            if (pop_now) coincide++;
          end else if (m_chan == NUM_CH && (m_data % 2) == 1) begin
            q.delete();
          end
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_write(input int chan, input int data, input int len, input bit rnd);
    int guard;
    chan_sel = CH_W'(chan);
    ibus.dmaster = 8'(data);
    wr_ena = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    guard = 0;
    while (obus.mwait !== 1'b1 && guard < 100) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    if (guard >= 100) chk("wait_timeout", 32'(obus.mwait), 32'd1);
    wr_ena = 1'b0;
    if (rnd) tx_ready = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic read_status(input string name, input int exp);
    chan_sel = CH_W'(NUM_CH);
    rd_ena = 1'b1;
    #1;
    chk(name, 32'(obus.dslave), exp);
    step();
    rd_ena = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int guard;

    rst_n = 1'b1; wr_ena = 1'b0; rd_ena = 1'b0; chan_sel = '0;
    ibus.dmaster = 8'h00; tx_ready = 1'b0;
    m_act = 1'b0; m_block = 1'b1;
    step();
    step();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_mwait", 32'(obus.mwait), 1);
    chk("rst_dslave", 32'(obus.dslave), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_chan", 32'(tx_chan), 0);
    rst_n = 1'b0;
    step();

    // First write lands one cycle after the strobe falls.
    do_write(1, 'h41, 3, 1'b0);
    chk("t1_valid", 32'(tx_valid), 1);
    chk("t1_data", 32'(tx_data), 'h41);
    chk("t1_chan", 32'(tx_chan), 1);
    chk("t1_count", 32'(fifo_count), 1);
    do_write(NUM_CH, 'h01, 1, 1'b0);

    // Fill to full, stall the 17th strobe, release it with a single pop.
    for (int i = 0; i < DEPTH; i++) do_write(i % 2, 'h60 + i, 1, 1'b0);
    chk("full_count", 32'(fifo_count), DEPTH);
    chan_sel = 2'd0; ibus.dmaster = 8'hEE; wr_ena = 1'b1;
    #1;
    chk("full_mwait", 32'(obus.mwait), 0);
    step();
    step();
    chk("still_waiting", 32'(obus.mwait), 0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("wait_released", 32'(obus.mwait), 1);
    chk("after_pop_head", 32'(tx_data), 'h61);
    wr_ena = 1'b0;
    step();
    chk("refill_count", 32'(fifo_count), DEPTH);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    tx_ready = 1'b0;
    chk("drained", 32'(fifo_count), 0);

    // Flush with five queued, then status.
    for (int i = 0; i < 5; i++) do_write(0, i + 1, 2, 1'b0);
    read_status("stat_5", 'h05);
    do_write(NUM_CH, 'h01, 2, 1'b0);
    chk("flush_count", 32'(fifo_count), 0);
    chk("flush_valid", 32'(tx_valid), 0);
    read_status("stat_empty", 'h40);

    for (int i = 0; i < 3; i++) do_write(1, 'h30 + i, 1, 1'b0);
    read_status("stat_3", 'h03);
    for (int i = 0; i < 13; i++) do_write(0, 'h80 + i, 1, 1'b0);
    read_status("stat_full", 'h90);
    do_write(NUM_CH, 'h01, 1, 1'b0);

    // Reset during a strobe, released with the strobe low.
    chan_sel = 2'd0; ibus.dmaster = 8'h77; wr_ena = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    wr_ena = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_mid_count", 32'(fifo_count), 0);
    chk("rst_mid_valid", 32'(tx_valid), 0);
    // Reset released with the strobe still high: that strobe is dropped.
    wr_ena = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    wr_ena = 1'b0;
    step();
    step();
    chk("rst_hold_count", 32'(fifo_count), 0);

    vt[0] = '{0, 'h41, 1, 1, 'h01};
    vt[1] = '{1, 'h42, 2, 2, 'h02};
    vt[2] = '{2, 'h00, 1, 2, 'h02};
    vt[3] = '{2, 'hFE, 3, 2, 'h02};
    vt[4] = '{2, 'h01, 1, 0, 'h40};
    vt[5] = '{1, 'h55, 2, 1, 'h01};
    for (int i = 0; i < 6; i++) begin
      do_write(vt[i].chan, vt[i].data, vt[i].len, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), vt[i].exp_count);
      read_status($sformatf("vec%0d_status", i), vt[i].exp_status);
    end
    do_write(NUM_CH, 'h01, 1, 1'b0);

    // Random writes with random drain: pointer wrap and push/pop overlap.
    for (int n = 0; n < 40; n++) begin
      do_write($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(1, 3), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        tx_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    tx_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      step();
      guard++;
    end
    step();
    tx_ready = 1'b0;
    chk("rand_drained", 32'(fifo_count), 0);
    chk("push_pop_overlap", (coincide > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffered_oport.md
# buffered_oport

Buffered, multi-channel successor to the single-character Z80 output port. CPU writes to one of `NUM_CH` output channels are queued as {channel, byte} entries in a `DEPTH`-entry FIFO and drained through a valid/ready stream toward a UART transmitter or a simulation console. The port inserts Z80 wait states when the FIFO is full, and exposes status and flush control through an extra control channel.

## Interface
- `NUM_CH`, 2: number of data channels; `chan_sel` value `NUM_CH` selects the control/status register.
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `CH_W`, `$clog2(NUM_CH+1)`: derived channel-select width; not overridable.
- `CNT_W`, `$clog2(DEPTH+1)`: derived occupancy-count width.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-high reset. Despite the name, `rst_n`=1 resets.
- `wr_ena`  in  1  level write strobe; high for the whole CPU write cycle, including wait states.
- `rd_ena`  in  1  level read strobe for the status register.
- `chan_sel`  in  CH_W  target channel, stable while either strobe is high.
- `ibus`  in  Z80MasterBus  `ibus.dmaster` carries write data.
- `obus`  out  Z80SlaveBus  `dslave` = read data; `mwait` is active-low wait.
- `tx_data`  out  8  head-entry byte.
- `tx_chan`  out  CH_W  head-entry channel.
- `tx_valid`  out  1  head entry valid.
- `tx_ready`  in  1  sink accepts head entry.
- `fifo_count`  out  CNT_W  current occupancy.

## Operation
- Write commit:
  - A `wr_delay` flag is set while `wr_ena`=1.
  - In the first cycle with `wr_ena`=0 and `wr_delay`=1, the byte is committed and `wr_delay` clears.
  - `ibus.dmaster` and `chan_sel` are sampled in every `wr_ena` cycle; the last sampled values are committed.
- Data channel (`chan_sel` < `NUM_CH`): push {chan, byte}.
- Control channel (`chan_sel` = `NUM_CH`): bit0=1 flushes the FIFO (count becomes 0, pointers reset); other bits are ignored and nothing is pushed.
- Backpressure:
  - `mwait` = 0 while `wr_ena`=1, `chan_sel` < `NUM_CH` and the FIFO is full; otherwise 1.
  - The commit is therefore guaranteed a free slot.
  - A commit never finding the FIFO full is an assertion-checked invariant.
- Status read:
  - `dslave` = {full, empty, count[5:0] saturated at 63} while `rd_ena`=1 and `chan_sel`=`NUM_CH`; otherwise `8'h00`.
  - Combinational from the registered state.
- Drain: pop when `tx_valid` && `tx_ready`. `tx_data`/`tx_chan` are undefined when `tx_valid`=0.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; both take effect.
  - Flush and pop in the same cycle: flush wins; count=0.
  - Flush and push cannot coincide (a single commit per strobe).
- Wrap-around: pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty is derived from `count`, not from pointer equality.
- Reset:
  - Clears `wr_delay`, pointers and count.
  - A write strobe in progress at reset is discarded, with no commit after reset release until a new strobe begins.
- Reset values: `tx_valid`=0, `fifo_count`=0, `obus.mwait`=1, `obus.dslave`=0, `tx_data`/`tx_chan`=0.

## Timing
- Write latency: `wr_ena` falls at cycle T → commit at edge T+1 → `tx_valid`=1 from T+1 if the FIFO was empty. `fifo_count` updates at the same edge.
- Pop: `tx_valid`&&`tx_ready` at edge E → next entry presented from E.
- Sustained drain: one entry per cycle with `tx_ready` held high.
- `mwait` responds in the same cycle as `wr_ena`/`count` changes (combinational). It deasserts in the cycle after the first pop from full.

## Configuration
- `BUFFERED_OPORT_CONSOLE_EN`
  - Defined: every pop executes `$write("%c", tx_data)`, and the FIFO is drained with `tx_ready` internally forced to 1, ignoring the `tx_ready` port. This is simulation-only.
  - Undefined: no system tasks, fully synthesizable; `tx_ready` governs draining.

## Structure
- `buffered_oport_pkg`: status bit positions (`STAT_FULL`=7, `STAT_EMPTY`=6), control bit `CTRL_FLUSH`=0, and an entry struct typedef parametrised via the package function for `CH_W`.
- Sub-module `sync_fifo`: generic `WIDTH`/`DEPTH` FIFO with `push`, `pop` and `flush` inputs, and `count`/`full`/`empty` outputs. `buffered_oport` owns the strobe decode, wait and status logic.

## Test plan
- Reset, then write 0x41 to ch1 (3-cycle strobe) → `tx_valid`=1, `tx_data`=0x41 and `tx_chan`=1 one cycle after `wr_ena` falls; `fifo_count`=1.
- `tx_ready`=0, then 16 writes (DEPTH=16) → 17th strobe sees `mwait`=0. Raise `tx_ready` for one cycle → `mwait`=1 the next cycle. Strobe release commits the 17th byte; FIFO order is preserved.
- Write 0x01 to control channel with 5 entries queued → `fifo_count`=0 and `tx_valid`=0 at the commit edge. Status read returns 0x40.
- With count=3, status read → `dslave`=0x03. With count=16, status read → 0x90.
- Assert `rst_n`=1 mid-strobe, release it while `wr_ena` is low → no entry pushed; `fifo_count`=0.
- Push 40 entries with random `tx_ready` → pointer wrap exercised; the stream matches the written sequence exactly, with push/pop coinciding at least once.
